// File: rtl/ov7670_frame_writer.sv
// OV7670 capture front end: turns the camera's VSYNC/HREF/byte stream into
// one memory write per RGB565 pixel at linear address y*H_RES + x.
// Addresses come from a running row base plus x, so no multiplier is needed.
module ov7670_frame_writer #(
   parameter int H_RES  = 320,
   parameter int V_RES  = 240,
   parameter int ADDR_W = 17
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        data,
   output logic              we,
   output logic [ADDR_W-1:0] wAddr,
   output logic [15:0]       wData,
   output logic              frame_done
);

   typedef enum logic [1:0] {
      SYNC   = 2'd0,
      BLANK  = 2'd1,
      ACTIVE = 2'd2
   } state_e;

   localparam logic [9:0]        X_MAX    = 10'd1023;
   localparam logic [7:0]        Y_MAX    = 8'd255;
   localparam logic [9:0]        X_LIM    = 10'(H_RES);
   localparam logic [7:0]        Y_LIM    = 8'(V_RES);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(H_RES);

   state_e              state_q, state_d;
   logic [9:0]          x_q, x_d;
   logic [7:0]          y_q, y_d;
   logic [ADDR_W-1:0]   row_base_q, row_base_d;
   logic                phase_q, phase_d;
   logic [7:0]          hi_byte_q, hi_byte_d;
   logic                href_q, href_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   waddr_q, waddr_d;
   logic [15:0]         wdata_q, wdata_d;
   logic                frame_done_q, frame_done_d;

   // State register; SYNC after reset so a partial frame is never captured.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= SYNC;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state: wait for a frame boundary, then track blanking vs. active.
   always_comb begin
      state_d = state_q;
      case (state_q)
         SYNC:    if (vsync)  state_d = BLANK;
         BLANK:   if (!vsync) state_d = ACTIVE;
         ACTIVE:  if (vsync)  state_d = BLANK;
         default: state_d = SYNC;
      endcase
   end

   // Datapath: byte pairing, x/y/row-base tracking, clipping and write strobe.
   always_comb begin
      x_d          = x_q;
      y_d          = y_q;
      row_base_d   = row_base_q;
      phase_d      = phase_q;
      hi_byte_d    = hi_byte_q;
      href_d       = href_q;
      we_d         = 1'b0;
      waddr_d      = waddr_q;
      wdata_d      = wdata_q;
      frame_done_d = 1'b0;

      if (state_q == ACTIVE && !vsync) begin
         href_d = href;
         if (href) begin
            if (!phase_q) begin
               hi_byte_d = data;
               phase_d   = 1'b1;
            end else begin
               phase_d = 1'b0;
               if (x_q < X_LIM && y_q < Y_LIM) begin
                  we_d    = 1'b1;
                  waddr_d = row_base_q + ADDR_W'(x_q);
                  wdata_d = {hi_byte_q, data};
               end
               if (x_q != X_MAX) begin
                  x_d = x_q + 10'd1;
               end
            end
         end else if (href_q) begin
            x_d     = '0;
            phase_d = 1'b0;
            if (y_q != Y_MAX) begin
               y_d = y_q + 8'd1;
            end
            if (y_q < Y_LIM) begin
               row_base_d = row_base_q + ROW_STEP;
            end
         end
      end else begin
         x_d        = '0;
         y_d        = '0;
         row_base_d = '0;
         phase_d    = 1'b0;
         href_d     = 1'b0;
         if (state_q == ACTIVE) begin
            frame_done_d = 1'b1;
         end
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_q          <= '0;
         y_q          <= '0;
         row_base_q   <= '0;
         phase_q      <= 1'b0;
         hi_byte_q    <= '0;
         href_q       <= 1'b0;
         we_q         <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
         frame_done_q <= 1'b0;
      end else begin
         x_q          <= x_d;
         y_q          <= y_d;
         row_base_q   <= row_base_d;
         phase_q      <= phase_d;
         hi_byte_q    <= hi_byte_d;
         href_q       <= href_d;
         we_q         <= we_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
         frame_done_q <= frame_done_d;
      end
   end

   assign we         = we_q;
   assign wAddr      = waddr_q;
   assign wData      = wdata_q;
   assign frame_done = frame_done_q;

endmodule
